// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the IF port, D port, memory port and busy.
// slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_ack;
   logic [DATA_W-1:0]     if_rdata;
   logic                  if_err;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_be;
   logic                  d_ack;
   logic [DATA_W-1:0]     d_rdata;
   logic                  d_err;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;

   logic                  busy;

   modport slave (
      input  if_req, if_addr,
      output if_ack, if_rdata, if_err,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_ack, d_rdata, d_err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata,
      output busy
   );

   modport master (
      output if_req, if_addr,
      input  if_ack, if_rdata, if_err,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_ack, d_rdata, d_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/D arbiter for a single-port memory.
// Optional access watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_if.slave    bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              grant_d;
   logic              any_req;
   logic              pick_d;
   logic              finish;
   logic              timed_out;
   logic [DATA_W-1:0] rdata_cap;

   // grant_d doubles as the owner of the current access and as last_grant
   assign any_req   = bus.if_req | bus.d_req;
   assign pick_d    = bus.d_req & (~bus.if_req | ~grant_d);
   assign finish    = (state == BUSY) & (bus.mem_ack | timed_out);
   assign rdata_cap = (bus.mem_ack & ~bus.mem_we) ? bus.mem_rdata : '0;
   assign bus.busy  = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [7:0] wait_cnt;
   logic       if_err_q;
   logic       d_err_q;

   assign timed_out  = (state == BUSY) & ~bus.mem_ack &
                       (wait_cnt == LAST_WAIT);
   assign bus.if_err = if_err_q;
   assign bus.d_err  = d_err_q;

   // count BUSY cycles without an acknowledge; zero outside BUSY
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state != BUSY) begin
         wait_cnt <= '0;
      end else if (!bus.mem_ack) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // error flag pulses alongside the owner's ack
   always_ff @(posedge clk) begin
      if (rst) begin
         if_err_q <= 1'b0;
         d_err_q  <= 1'b0;
      end else begin
         if_err_q <= 1'b0;
         d_err_q  <= 1'b0;
         if (finish) begin
            if (grant_d) d_err_q  <= timed_out;
            else         if_err_q <= timed_out;
         end
      end
   end
`else
   assign timed_out  = 1'b0;
   assign bus.if_err = 1'b0;
   assign bus.d_err  = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state: grant in IDLE, wait in BUSY, single DONE cycle
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (finish)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // latch the winning request into the memory port, hold until ack
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_d       <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_be    <= '0;
      end else if (state == IDLE && any_req) begin
         grant_d       <= pick_d;
         bus.mem_req   <= 1'b1;
         bus.mem_we    <= pick_d & bus.d_we;
         bus.mem_addr  <= pick_d ? bus.d_addr : bus.if_addr;
         bus.mem_wdata <= (pick_d & bus.d_we) ? bus.d_wdata : '0;
         bus.mem_be    <= (pick_d & bus.d_we) ? bus.d_be : '1;
      end else if (finish) begin
         bus.mem_req   <= 1'b0;
      end
   end

   // completion: one-cycle ack and held read data per port
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.if_ack   <= 1'b0;
         bus.d_ack    <= 1'b0;
         bus.if_rdata <= '0;
         bus.d_rdata  <= '0;
      end else begin
         bus.if_ack <= 1'b0;
         bus.d_ack  <= 1'b0;
         if (finish) begin
            if (grant_d) begin
               bus.d_ack   <= 1'b1;
               bus.d_rdata <= rdata_cap;
            end else begin
               bus.if_ack   <= 1'b1;
               bus.if_rdata <= rdata_cap;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random IF/D traffic, random-latency memory,
// transaction-level reference model with round-robin rule.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TMO    = 4;
   localparam int MAXW   = 6;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 15;
   localparam int MAXW   = 3;
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int CYCLES = 3000;

   typedef struct packed {
      logic          req;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [3:0]    be;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   txn_t          rq [2];
   txn_t          m_txn;
   int            m_phase;
   int            m_last;
   int            m_owner;
   int            m_wait;
   int            m_bcnt;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   logic [DW-1:0] m_hold [2];
   bit            chk_rst;
   logic [DW-1:0] dev_mem [8];
   logic [DW-1:0] ref_mem [8];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic txn_t new_txn(input int p);
      txn_t t;
      t.req   = 1'b1;
      t.addr  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      t.we    = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      t.wdata = $urandom;
      t.be    = 4'($urandom_range(1, 15));
      return t;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] wd,
                                           input logic [3:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic drive_reqs();
      bus.if_req  = rq[0].req;
      bus.if_addr = rq[0].addr;
      bus.d_req   = rq[1].req;
      bus.d_we    = rq[1].we;
      bus.d_addr  = rq[1].addr;
      bus.d_wdata = rq[1].wdata;
      bus.d_be    = rq[1].be;
   endtask

   // advance the reference model over the cycle that just ended
   task automatic update();
      int idx;
      if (rst) begin
         m_phase   = 0;
         m_last    = 0;
         m_hold[0] = '0;
         m_hold[1] = '0;
         chk_rst   = 1'b1;
         return;
      end
      chk_rst = 1'b0;
      case (m_phase)
         0: begin
            if (rq[0].req || rq[1].req) begin
               if (rq[0].req && rq[1].req) m_owner = 1 - m_last;
               else m_owner = rq[1].req ? 1 : 0;
               m_last  = m_owner;
               m_txn   = rq[m_owner];
               m_phase = 1;
               m_bcnt  = 0;
               m_wait  = $urandom_range(0, MAXW);
            end
         end
         1: begin
            m_bcnt++;
            idx = int'(m_txn.addr[4:2]);
            if (bus.mem_ack) begin
               m_err = 1'b0;
               if (m_txn.we) begin
                  ref_mem[idx] = merge(ref_mem[idx], m_txn.wdata, m_txn.be);
                  m_rdata = '0;
               end else begin
                  m_rdata = ref_mem[idx];
               end
               m_phase = 2;
               m_hold[m_owner] = m_rdata;
            end else if (TMO_EN && m_bcnt == TMO) begin
               m_err   = 1'b1;
               m_rdata = '0;
               m_phase = 2;
               m_hold[m_owner] = m_rdata;
            end else begin
               m_wait--;
            end
         end
         default: begin
            if ($urandom_range(0, 3) != 0) rq[m_owner] = new_txn(m_owner);
            else rq[m_owner].req = 1'b0;
            m_phase = 0;
         end
      endcase
   endtask

   task automatic sample();
      int idx;
      check("busy", bus.busy, m_phase != 0);
      check("mem_req", bus.mem_req, m_phase == 1);
      if (m_phase == 1) begin
         check("mem_addr", bus.mem_addr, m_txn.addr);
         check("mem_we", bus.mem_we, m_txn.we);
         if (m_txn.we) begin
            check("mem_wdata", bus.mem_wdata, m_txn.wdata);
            check("mem_be", bus.mem_be, m_txn.be);
         end else if (m_owner == 0) begin
            check("mem_be_fetch", bus.mem_be, 4'hF);
         end
      end
      check("if_ack", bus.if_ack, m_phase == 2 && m_owner == 0);
      check("d_ack", bus.d_ack, m_phase == 2 && m_owner == 1);
      check("if_rdata", bus.if_rdata, m_hold[0]);
      check("d_rdata", bus.d_rdata, m_hold[1]);
      check("if_err", bus.if_err, m_phase == 2 && m_owner == 0 && m_err);
      check("d_err", bus.d_err, m_phase == 2 && m_owner == 1 && m_err);
      if (chk_rst) begin
         check("rst_mem_addr", bus.mem_addr, '0);
         check("rst_mem_we", bus.mem_we, 1'b0);
         check("rst_mem_wdata", bus.mem_wdata, '0);
         check("rst_mem_be", bus.mem_be, '0);
      end
      if (bus.mem_ack && bus.mem_req && bus.mem_we) begin
         idx = int'(bus.mem_addr[4:2]);
         dev_mem[idx] = merge(dev_mem[idx], bus.mem_wdata, bus.mem_be);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         dev_mem[i] = $urandom;
         ref_mem[i] = dev_mem[i];
      end
      rq[0]         = '0;
      rq[1]         = '0;
      m_phase       = 0;
      m_last        = 0;
      m_owner       = 0;
      m_wait        = 0;
      m_bcnt        = 0;
      m_err         = 1'b0;
      m_rdata       = '0;
      m_hold[0]     = '0;
      m_hold[1]     = '0;
      chk_rst       = 1'b0;
      m_txn         = '0;
      drive_reqs();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         update();
         rst = (cyc < 2) ||
               (m_phase == 1 && m_bcnt == 1 && $urandom_range(0, 9) == 0);
         for (int p = 0; p < 2; p++)
            if (!rq[p].req && $urandom_range(0, 2) == 0) rq[p] = new_txn(p);
         drive_reqs();
         if (!rst && m_phase == 1 && m_wait == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = dev_mem[bus.mem_addr[4:2]];
         end else if (!rst && m_phase != 1 && $urandom_range(0, 7) == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
         end
         @(negedge clk);
         sample();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port unified memory of `Chip` between the instruction-fetch requester (IF, read-only) and the load/store requester (D, read/write). It accepts one request at a time and forwards it to memory with registered address, data and control. It waits for the memory acknowledge and returns data or an error to the winning port. Ties are resolved round-robin, so neither port starves.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `TIMEOUT`, 15, cycles to wait for `mem_ack` before aborting (used only when the watchdog is compiled in; legal range 1..255)
- `clk`  in  1  single clock; all logic is on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request, held high until `if_ack`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req` is high
- `if_ack`  out  1  one-cycle completion pulse
- `if_rdata`  out  DATA_W  fetch data, valid while `if_ack` is high
- `if_err`  out  1  high with `if_ack` when the access timed out
- `d_req`  in  1  data request, held high until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_be`  in  DATA_W/8  store byte enables; ignored for loads
- `d_ack`  out  1  one-cycle completion pulse
- `d_rdata`  out  DATA_W  load data, valid while `d_ack` is high; 0 for stores
- `d_err`  out  1  high with `d_ack` when the access timed out
- `mem_req`  out  1  memory request, held until `mem_ack` is sampled
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  registered copies of the granted request; `mem_be` is all-ones for fetches
- `mem_ack`  in  1  memory completion, one cycle, only while `mem_req` is high
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - No request: stay in IDLE.
  - Exactly one of `if_req`/`d_req` high: grant that port, latch its request into the `mem_*` registers, go to BUSY.
  - Both high: grant the port other than `last_grant`.
  - `last_grant` is updated on every grant and resets to IF, so the first tie after reset goes to D.
- BUSY
  - `mem_req`=1; the `mem_*` outputs are frozen.
  - On a sampled `mem_ack`: capture `mem_rdata` (loads and fetches only; 0 for stores), drop `mem_req`, go to DONE.
- DONE
  - Exactly one cycle. The granted port's ack is high, with rdata and err.
  - Requests are ignored in this state. Next state is IDLE.
- A requester that keeps `req` high in the cycle after its ack is issuing a new request. That request competes in IDLE.
- The non-granted port's request waits and is never dropped. Its inputs are not sampled until it is granted.
- Reset value of every output is 0.
- Reset at any time, including mid-BUSY:
  - Next state is IDLE, `last_grant` is IF, and no ack is issued.
  - The outstanding memory access is abandoned. Memory shares `rst`.

## Timing
- Request sampled in IDLE at cycle 0 → `mem_req` high in cycle 1.
- `mem_ack` in cycle k≥1 → requester ack in cycle k+1 → IDLE in cycle k+2.
- With zero-wait memory (ack in cycle 1):
  - Latency is 2 cycles from request to ack.
  - Throughput is one access every 3 cycles.
- `mem_ack` outside BUSY is ignored.
- `if_rdata`/`d_rdata` are registered and hold their value until the next completion on that port.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`.
  - When the count reaches `TIMEOUT`: drop `mem_req`, go to DONE, pulse the port's ack with err=1 and rdata=0.
  - `mem_ack` arriving in the same cycle as the timeout wins: normal completion, err=0.
- Not defined:
  - BUSY waits indefinitely.
  - `if_err`/`d_err` are tied to 0.
  - No counter logic is generated.

## Test plan
- Reset, then IF read of 0x100 with zero-wait memory returning 0xDEADBEEF → `mem_req` in cycle 1, `if_ack` with `if_rdata`=0xDEADBEEF in cycle 2, `busy` low in cycle 3.
- D store of 0xA5A5A5A5 to 0x200 with `d_be`=0x3, memory acks after 3 waits → `mem_we`=1, `mem_be`=0x3, `mem_wdata`=0xA5A5A5A5 held for 4 cycles; `d_ack` once; `d_rdata`=0.
- `if_req` and `d_req` both held continuously, zero-wait memory → grants alternate D, IF, D, IF; each port gets one ack every 6 cycles.
- `rst` pulsed in the second BUSY cycle of an IF read → no `if_ack`, all outputs 0 next cycle; a subsequent tie is granted to D.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT`=4, memory never acks a D load → `d_ack`=1, `d_err`=1, `d_rdata`=0 exactly 4 BUSY cycles after grant; a following IF read completes normally.
- `mem_ack` pulsed while IDLE, then an IF read → stray ack ignored; one `if_ack` returns the correct data.
